// File: rtl/sine_dac_pkg.sv
// Shared types and helpers for the sine oscillator DAC output path.
//   state_t          : serialiser FSM states
//   frame_bits()     : total bits per SPI frame (command + data)
//   to_offset_binary : two's complement -> offset binary by MSB inversion
package sine_dac_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, TRAIL, GAP} state_t;

    function automatic int frame_bits(input int cmd_w, input int data_w);
        return cmd_w + data_w;
    endfunction

    // Works on a 64-bit container; caller truncates to its sample width.
    function automatic logic [63:0] to_offset_binary(input logic [63:0] d,
                                                     input int w,
                                                     input bit en);
        logic [63:0] msb;
        msb = 64'd1 << (w - 1);
        return en ? (d ^ msb) : d;
    endfunction

endpackage

// File: rtl/sine_dac_spi_tx_timer.sv
// Phase timer for the SPI serialiser.
//   clk, reset_n : clock, synchronous active-low reset
//   load         : (re)start the timer this cycle
//   sel_gap      : 1 = time GAP_CYC cycles, 0 = time CLK_DIV cycles
//   done         : high during the last cycle of the timed interval
module spi_phase_timer #(
    parameter int CLK_DIV = 4,
    parameter int GAP_CYC = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic sel_gap,
    output logic done
);

    localparam int MAXV = (CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC;
    localparam int TW   = (MAXV > 1) ? $clog2(MAXV + 1) : 1;

    logic [TW-1:0] cnt;
    logic          active;

    // Loaded with N-1 so that done lands on the Nth cycle after the load
    // edge, letting the FSM act and reload on the very next edge.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt    <= '0;
            active <= 1'b0;
        end else if (load) begin
            cnt    <= sel_gap ? TW'(GAP_CYC - 1) : TW'(CLK_DIV - 1);
            active <= 1'b1;
        end else if (active) begin
            if (cnt == '0) active <= 1'b0;
            else           cnt    <= cnt - TW'(1);
        end
    end

    assign done = active && (cnt == '0);

endmodule

// File: rtl/sine_dac_spi_tx.sv
// Serialises oscillator samples to a 16-bit SPI DAC (mode 0, MSB first).
// Frame = {CMD_VAL, sample}, sample optionally converted to offset binary.
//   clk, reset_n : clock, synchronous active-low reset
//   s_data/s_valid/s_ready : sample input handshake (accept = valid & ready)
//   dac_cs_n, dac_sclk, dac_mosi : SPI pins, all registered
//   busy        : frame in progress
//   overrun_cnt : saturating count of samples offered while not ready
module sine_dac_spi_tx
    import sine_dac_pkg::*;
#(
    parameter int               DATA_W     = 16,
    parameter int               CMD_W      = 8,
    parameter logic [CMD_W-1:0] CMD_VAL    = 8'h00,
    parameter int               CLK_DIV    = 4,
    parameter int               GAP_CYC    = 4,
    parameter bit               OFFSET_BIN = 1'b1,
    parameter int               CNT_W      = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic signed [DATA_W-1:0] s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic                     dac_cs_n,
    output logic                     dac_sclk,
    output logic                     dac_mosi,
    output logic                     busy,
    output logic [CNT_W-1:0]         overrun_cnt
);

    localparam int FB = frame_bits(CMD_W, DATA_W);
    localparam int IW = $clog2(FB);

    state_t        state;
    logic [FB-1:0] shreg;
    logic [FB-1:0] word;
    logic [IW-1:0] bit_idx;
    logic          accept, drop;
    logic          t_load, t_gap, t_done;

    assign word   = {CMD_VAL, DATA_W'(to_offset_binary(64'(s_data), DATA_W, OFFSET_BIN))};
    assign accept = s_valid && s_ready;
    assign drop   = s_valid && !s_ready;

    // Every phase boundary restarts the timer; only TRAIL->GAP uses GAP_CYC.
    always_comb begin
        t_load = 1'b0;
        t_gap  = 1'b0;
        case (state)
            IDLE:  t_load = accept;
            SHIFT: t_load = t_done;
            TRAIL: begin
                t_load = t_done;
                t_gap  = 1'b1;
            end
            default: ;
        endcase
    end

    spi_phase_timer #(
        .CLK_DIV (CLK_DIV),
        .GAP_CYC (GAP_CYC)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (t_load),
        .sel_gap (t_gap),
        .done    (t_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= IDLE;
            dac_cs_n    <= 1'b1;
            dac_sclk    <= 1'b0;
            dac_mosi    <= 1'b0;
            s_ready     <= 1'b1;
            busy        <= 1'b0;
            overrun_cnt <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
        end else begin
            if (drop && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + CNT_W'(1);

            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg    <= word;
                        dac_mosi <= word[FB-1];
                        dac_cs_n <= 1'b0;
                        s_ready  <= 1'b0;
                        busy     <= 1'b1;
                        bit_idx  <= IW'(FB - 1);
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (t_done) begin
                        if (!dac_sclk) begin
                            dac_sclk <= 1'b1;
                        end else begin
                            // End of a high phase: next low phase starts,
                            // which is the only point mosi may change.
                            dac_sclk <= 1'b0;
                            if (bit_idx == '0) begin
                                state <= TRAIL;
                            end else begin
                                bit_idx  <= bit_idx - IW'(1);
                                shreg    <= {shreg[FB-2:0], 1'b0};
                                dac_mosi <= shreg[FB-2];
                            end
                        end
                    end
                end
                TRAIL: begin
                    if (t_done) begin
                        dac_cs_n <= 1'b1;
                        dac_mosi <= 1'b0;
                        state    <= GAP;
                    end
                end
                GAP: begin
                    if (t_done) begin
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
